// File: rtl/div16_if.sv
// rtl/div16_if.sv - start/done handshake bundle for the div16 sequential divider
// Signals:
//   start     request, sampled by the divider only while busy=0
//   in_17bit  dividend, 17-bit two's complement
//   in_8bit   divisor, 8-bit two's complement Q1.7
//   busy      operation in flight
//   done      one-cycle pulse when out/div_zero are updated
//   div_zero  last result came from a zero divisor
//   out       17-bit two's complement saturated quotient
// Modports: master drives the request, slave (the divider) drives the result.
interface div16_if;
  logic        start;
  logic [16:0] in_17bit;
  logic [7:0]  in_8bit;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [16:0] out;

  modport master (
    output start, in_17bit, in_8bit,
    input  busy, done, div_zero, out
  );

  modport slave (
    input  start, in_17bit, in_8bit,
    output busy, done, div_zero, out
  );
endinterface

// File: rtl/div16.sv
// rtl/div16.sv - restoring divider computing sat((in_17bit * 128) / in_8bit), one bit per clock
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    div16_if.slave: start/in_17bit/in_8bit in, busy/done/div_zero/out out
// Latency: start accepted at edge k -> out/div_zero/done updated at edge k+25.
module div16 (
  input  logic   clk,
  input  logic   rst_n,
  div16_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_q;
  logic        sign_q;
  logic [23:0] dvd_q;   // dividend magnitude, refilled from the LSB with quotient bits
  logic [7:0]  dsr_q;
  logic [8:0]  rem_q;
  logic [4:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;
  logic [16:0] out_q;

  logic [16:0] mag17_d;
  logic [7:0]  mag8_d;
  logic [9:0]  rem_sh;
  logic        qbit_d;
  logic [8:0]  rem_d;
  logic [16:0] res_d;

  // Two's-complement negation; the 17-bit result of -(-65536) reads as unsigned 65536.
  always_comb begin
    mag17_d = bus.in_17bit[16] ? (~bus.in_17bit + 17'd1) : bus.in_17bit;
    mag8_d  = bus.in_8bit[7]   ? (~bus.in_8bit + 8'd1)   : bus.in_8bit;
  end

  // One restoring step. When the subtraction happens the result is below the divisor,
  // and when it does not rem_sh[9] is already 0, so 9 bits always hold the remainder.
  always_comb begin
    rem_sh = {rem_q, dvd_q[23]};
    qbit_d = (rem_sh >= {2'b00, dsr_q});
    rem_d  = qbit_d ? (rem_sh[8:0] - {1'b0, dsr_q}) : rem_sh[8:0];
  end

  // Sign and saturation. A zero divisor forces sign_q to the dividend sign, since
  // in_8bit[7] was 0 when it was latched.
  always_comb begin
    res_d = 17'd0;
    if (dsr_q == 8'd0) begin
      res_d = sign_q ? 17'h10000 : 17'h0FFFF;
    end else if (sign_q) begin
      res_d = (dvd_q > 24'd65536) ? 17'h10000 : (~dvd_q[16:0] + 17'd1);
    end else begin
      res_d = (dvd_q > 24'd65535) ? 17'h0FFFF : dvd_q[16:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dvd_q   <= 24'd0;
      dsr_q   <= 8'd0;
      rem_q   <= 9'd0;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= 17'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sign_q  <= bus.in_17bit[16] ^ bus.in_8bit[7];
            dvd_q   <= {mag17_d, 7'd0};
            dsr_q   <= mag8_d;
            rem_q   <= 9'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[22:0], qbit_d};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          out_q   <= res_d;
          dz_q    <= (dsr_q == 8'd0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.out      = out_q;

endmodule

// File: tb/tb_div16.sv
// tb/tb_div16.sv - self-checking bench for div16: vector table, handshake sequences, random ops vs model
module tb_div16;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  int   cyc;

  div16_if bus ();

  div16 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int a;
    int b;
    int exp_o;
    bit exp_dz;
  } vec_t;

  task automatic chk(input string nm, input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, tag, got, got, exp, exp);
  endtask

  // Reference: exact integer arithmetic, truncation toward zero, then clamp.
  function automatic void model(input int a, input int b, output logic [16:0] o, output logic dz);
    int q;
    if (b == 0) begin
      dz = 1'b1;
      q  = (a >= 0) ? 65535 : -65536;
    end else begin
      dz = 1'b0;
      q  = (a * 128) / b;
      if (q > 65535)  q = 65535;
      if (q < -65536) q = -65536;
    end
    o = q[16:0];
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk(nm, "idle_timeout", bus.busy, 0);
  endtask

  // Issue one operation, scramble inputs after acceptance, optionally poke start
  // mid-operation, and check latency, busy, result and done width.
  task automatic op_check(input string nm, input int a, input int b,
                          input logic [16:0] exp_o, input logic exp_dz, input bit inj);
    int   lat;
    logic busy_bad;
    wait_idle(nm);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_17bit = a[16:0];
    bus.in_8bit  = b[7:0];
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.in_17bit = 17'($urandom);
    bus.in_8bit  = 8'($urandom);
    chk(nm, "busy_at_accept", bus.busy, 1);
    lat      = 0;
    busy_bad = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (inj && n == 10) begin
        bus.start    = 1'b1;
        bus.in_17bit = 17'd3;
        bus.in_8bit  = 8'd1;
      end
      if (inj && n == 11) bus.start = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busy_bad = 1'b1;
    end
    chk(nm, "latency", lat, 25);
    chk(nm, "out", {15'd0, bus.out}, {15'd0, exp_o});
    chk(nm, "div_zero", {31'd0, bus.div_zero}, {31'd0, exp_dz});
    chk(nm, "busy_during_op", {31'd0, busy_bad}, 0);
    chk(nm, "busy_at_done", {31'd0, bus.busy}, 0);
    @(posedge clk);
    #1;
    chk(nm, "done_one_cycle", {31'd0, bus.done}, 0);
  endtask

  initial begin
    vec_t        tbl[$];
    logic [16:0] mo;
    logic        mdz;
    int          ra [0:5];
    int          rb [0:5];
    int          last_done;
    int          n;
    bit          seen;

    passed = 0;
    total  = 0;
    bus.start    = 1'b0;
    bus.in_17bit = 17'd0;
    bus.in_8bit  = 8'd0;
    rst_n        = 1'b0;

    tbl.push_back('{4360, 127, 4394, 1'b0});
    tbl.push_back('{256, 127, 258, 1'b0});
    tbl.push_back('{-4360, 127, -4394, 1'b0});
    tbl.push_back('{1000, -128, -1000, 1'b0});
    tbl.push_back('{-1000, -128, 1000, 1'b0});
    tbl.push_back('{65535, 1, 65535, 1'b0});
    tbl.push_back('{-65536, 1, -65536, 1'b0});
    tbl.push_back('{-65536, -128, 65535, 1'b0});
    tbl.push_back('{5, 0, 65535, 1'b1});
    tbl.push_back('{-5, 0, -65536, 1'b1});
    tbl.push_back('{256, 127, 258, 1'b0});
    tbl.push_back('{-1, 127, -1, 1'b0});
    tbl.push_back('{0, 5, 0, 1'b0});
    tbl.push_back('{1, -1, -128, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset", "busy", {31'd0, bus.busy}, 0);
    chk("reset", "done", {31'd0, bus.done}, 0);
    chk("reset", "out", {15'd0, bus.out}, 0);
    chk("reset", "div_zero", {31'd0, bus.div_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      op_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
               17'(tbl[i].exp_o), tbl[i].exp_dz, 1'b0);
    end

    // Mid-CALC abort: outputs (left nonzero by the last divide-by-zero-free op) clear asynchronously.
    op_check("pre_abort", -65536, 1, 17'h10000, 1'b0, 1'b0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_17bit = 17'd4360;
    bus.in_8bit  = 8'h7F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort", "busy", {31'd0, bus.busy}, 0);
    chk("abort", "done", {31'd0, bus.done}, 0);
    chk("abort", "out", {15'd0, bus.out}, 0);
    chk("abort", "div_zero", {31'd0, bus.div_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort", "no_done_after", {31'd0, seen}, 0);

    // start pulsed 10 cycles into an op must not disturb it or queue a second op.
    op_check("ignored_start", 1000, -128, -17'sd1000, 1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("ignored_start", "no_second_op", {31'd0, seen}, 0);

    // start held high: one result every 26 clocks, inputs changed while busy.
    for (int i = 0; i < 6; i++) begin
      ra[i] = int'($urandom_range(0, 131071)) - 65536;
      rb[i] = int'($urandom_range(0, 255)) - 128;
    end
    rb[2] = 0;
    wait_idle("stream");
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_17bit = ra[0][16:0];
    bus.in_8bit  = rb[0][7:0];
    @(posedge clk);
    #1;
    bus.in_17bit = ra[1][16:0];
    bus.in_8bit  = rb[1][7:0];
    last_done = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!bus.done && n < 60) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk($sformatf("stream%0d", i), "done_seen", {31'd0, bus.done}, 1);
      model(ra[i], rb[i], mo, mdz);
      chk($sformatf("stream%0d", i), "out", {15'd0, bus.out}, {15'd0, mo});
      chk($sformatf("stream%0d", i), "div_zero", {31'd0, bus.div_zero}, {31'd0, mdz});
      if (i > 0) chk($sformatf("stream%0d", i), "period", cyc - last_done, 26);
      last_done = cyc;
      if (i < 3) begin
        @(posedge clk);
        #1;
        bus.in_17bit = ra[i + 2][16:0];
        bus.in_8bit  = rb[i + 2][7:0];
      end
    end
    bus.start = 1'b0;

    // Random ops against the arithmetic model, with zero and extreme operands mixed in.
    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = int'($urandom_range(0, 131071)) - 65536;
      b = int'($urandom_range(0, 255)) - 128;
      case (i % 8)
        0: b = 0;
        1: a = -65536;
        2: b = -128;
        3: b = ($urandom_range(0, 1) != 0) ? 1 : -1;
        default: ;
      endcase
      model(a, b, mo, mdz);
      op_check($sformatf("rand%0d(%0d/%0d)", i, a, b), a, b, mo, mdz, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div16.md
# div16

Sequential fixed-point divider, the inverse of the FFT datapath's multi16 scaling multiplier. Takes a 17-bit two's-complement value and an 8-bit two's-complement Q1.7 factor and returns the 17-bit quotient (in_17bit × 128) / in_8bit, saturated. Used to undo twiddle or gain scaling on the same word formats. Uses one restoring-division bit per clock behind a start/done handshake.

## Interface
- No parameters; widths are fixed at 17/8/17 to match multi16.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- in_17bit  in  17  dividend, two's complement, range -65536..65535.
- in_8bit  in  8  divisor, two's complement Q1.7, range -128..127.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when out and div_zero are updated.
- div_zero  out  1  high with the result if the divisor was 0; held until the next result.
- out  out  17  quotient, two's complement; held until the next result.

## Operation
- States: IDLE, CALC, FIN.
- IDLE, start=1 at a clock edge:
  - Latch sign_q = in_17bit[16] ^ in_8bit[7].
  - Latch the 24-bit magnitude |in_17bit|<<7 and the 8-bit magnitude |in_8bit|. The magnitudes of -65536 and -128 are exact.
  - Clear the 5-bit iteration counter and the 9-bit remainder. Go to CALC.
- CALC runs 24 iterations, one per edge, MSB first:
  - Shift the next dividend bit into the remainder.
  - If remainder >= divisor magnitude: subtract it, quotient bit = 1. Otherwise quotient bit = 0.
  - After the iteration with counter = 23, go to FIN.
- FIN, at one edge:
  - Apply the sign to the 24-bit magnitude quotient. The result truncates toward zero.
  - Saturate to the range -65536..65535.
  - Register the result into out, set div_zero, pulse done. Return to IDLE.
- Divisor = 0:
  - Same latency; the CALC result is ignored.
  - out = 65535 if in_17bit >= 0, otherwise -65536. div_zero = 1.
- Inputs are captured at start; later input changes have no effect on the operation in flight.
- start while busy=1 is ignored; there is no queueing.
- Remainder arithmetic is unsigned. The quotient magnitude needs at most 24 bits (65536·128/1).

## Timing
- Reset (async, any state): state=IDLE, busy=0, done=0, div_zero=0, out=0, internal registers=0.
- Reset asserted mid-operation aborts it. No done is produced for the aborted request.
- Let start be accepted at edge k:
  - busy=1 from edge k through edge k+24 (25 cycles), and 0 after edge k+25.
  - out, div_zero and done are updated at edge k+25. done is high for exactly the one cycle after edge k+25.
  - Start-to-done latency is 25 clocks.
- Back-to-back: start may be high during the done cycle. It is accepted at edge k+26, giving one result every 26 clocks.
- out and div_zero are stable between done pulses.

## Test plan
- Reset: hold rst_n=0 mid-CALC, release -> busy=0, done=0, out=0, div_zero=0. No done pulse ever follows for the aborted op.
- Nominal values:
  - in_17bit=17'b00001000100001000 (4360), in_8bit=8'h7F -> out=4394 exactly 25 clocks after the accepting edge, done for one cycle.
  - Then in_17bit=256, in_8bit=8'h7F -> out=258.
- Signs:
  - in_17bit=-4360, in_8bit=127 -> out=-4394.
  - in_17bit=1000, in_8bit=-128 -> out=-1000.
  - in_17bit=-1000, in_8bit=-128 -> out=1000.
- Saturation:
  - in_17bit=65535, in_8bit=1 -> out=65535.
  - in_17bit=-65536, in_8bit=1 -> out=-65536.
  - in_17bit=-65536, in_8bit=-128 -> out=65535.
- Divide by zero:
  - in_17bit=5, in_8bit=0 -> out=65535, div_zero=1.
  - in_17bit=-5, in_8bit=0 -> out=-65536, div_zero=1.
  - Next valid op clears div_zero.
- Handshake:
  - Pulse start again 10 cycles into an op with different inputs -> ignored; the first result is unchanged.
  - start held high continuously -> done pulses every 26 clocks, each with the correct result.
